// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the VRAM arbiter slice.
//   ADDR_W/DATA_W/DEPTH  VRAM geometry (80 words/line x 120 lines)
//   req_id_t             requester id (display / CPU)
//   resp_tag_t           per-access tag carried down the response pipeline
//   arb_state_t          arbiter FSM state
package vram_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 9600;

  typedef enum logic {REQ_DISP = 1'b0, REQ_CPU = 1'b1} req_id_t;

  typedef struct packed {
    req_id_t id;
    logic    is_read;
    logic    in_range;
  } resp_tag_t;

  typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} arb_state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(DEPTH);
  endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, CPU and VRAM-side signals of the arbiter.
//   modport slave  : arbiter view (takes requests, drives grants/responses and mem_*)
//   modport master : environment view (requesters and the VRAM itself)
interface vram_arbiter_if;
  import vram_pkg::*;

  logic              disp_req;
  logic              disp_urgent;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_urgent, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_req, disp_urgent, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter_arb_rr2.sv
// arb_rr2: 2-way round-robin picker with display priority override.
//   clk, rst_n : clock, async active-low reset
//   en         : grants allowed this cycle
//   urgent     : display request takes strict priority
//   req[1:0]   : requests indexed by req_id_t
//   gnt[1:0]   : one-hot (or zero) grant, combinational
// Pointer names the side that wins a tie; resets to CPU.
module arb_rr2
  import vram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       urgent,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  req_id_t ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[REQ_DISP] && urgent) gnt[REQ_DISP] = 1'b1;
      else if (&req)               gnt[ptr]      = 1'b1;
      else                         gnt           = req;
    end
  end

  // Hand the tie to whichever side did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= REQ_CPU;
    else if (|gnt)    ptr <= gnt[REQ_CPU] ? REQ_DISP : REQ_CPU;
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the synchronous-read VRAM port between the scanline
// fetcher (display) and the CPU screen window.
//   clk, rst_n     : clock, async active-low reset
//   mem_ready      : VRAM loaded; no grants while low
//   bus (slave)    : display/CPU request+response, mem_* strobes, mem_rdata
//   cpu_stall_cnt  : (VRAM_ARB_STATS_EN only) saturating count of cycles the
//                    CPU requested without a grant
// Timing: gnt in cycle N, mem_* registered at N+1, rvalid/rdata at N+2.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_ready,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]    cpu_stall_cnt,
`endif
  vram_arbiter_if.slave  bus
);
  localparam int STAGES = 2;

  arb_state_t state, state_nxt;
  logic       gnt_en;
  logic [1:0] req, gnt;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: if (mem_ready)  state_nxt = ST_RUN;
      ST_RUN:  if (!mem_ready) state_nxt = ST_WAIT;
      default: state_nxt = ST_WAIT;
    endcase
  end

  // FSM: outputs. Grants open in the very cycle mem_ready rises and close
  // in the very cycle it falls.
  always_comb begin
    gnt_en = 1'b0;
    case (state)
      ST_WAIT: gnt_en = mem_ready;
      ST_RUN:  gnt_en = mem_ready;
      default: gnt_en = 1'b0;
    endcase
  end

  assign req[REQ_DISP] = bus.disp_req;
  assign req[REQ_CPU]  = bus.cpu_req;

  arb_rr2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (gnt_en),
    .urgent (bus.disp_urgent),
    .req    (req),
    .gnt    (gnt)
  );

  assign bus.disp_gnt = gnt[REQ_DISP];
  assign bus.cpu_gnt  = gnt[REQ_CPU];

  // Selected request
  logic              sel_cpu;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_ok;

  assign sel_cpu  = gnt[REQ_CPU];
  assign sel_addr = sel_cpu ? bus.cpu_addr : bus.disp_addr;
  assign sel_we   = sel_cpu & bus.cpu_we;
  assign sel_ok   = addr_ok(sel_addr);

  // VRAM strobes; out-of-range accesses never reach the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= (|gnt) & sel_ok;
      bus.mem_we <= (|gnt) & sel_ok & sel_we;
      if (|gnt) begin
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= bus.cpu_wdata;
      end
    end
  end

  // Response tag pipeline
  logic [STAGES:0] vld_pipe;
  resp_tag_t       tag_pipe [STAGES:0];

  assign vld_pipe[0]          = |gnt;
  assign tag_pipe[0].id       = sel_cpu ? REQ_CPU : REQ_DISP;
  assign tag_pipe[0].is_read  = ~sel_we;
  assign tag_pipe[0].in_range = sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  resp_tag_t         tag_out;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] disp_hold, cpu_hold;

  assign tag_out = tag_pipe[STAGES];
  assign rd_val  = tag_out.in_range ? bus.mem_rdata : '0;

  assign bus.disp_rvalid = vld_pipe[STAGES] & tag_out.is_read & (tag_out.id == REQ_DISP);
  assign bus.cpu_rvalid  = vld_pipe[STAGES] & tag_out.is_read & (tag_out.id == REQ_CPU);

  // Read data is passed through on rvalid and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_hold <= '0;
      cpu_hold  <= '0;
    end else begin
      if (bus.disp_rvalid) disp_hold <= rd_val;
      if (bus.cpu_rvalid)  cpu_hold  <= rd_val;
    end
  end

  assign bus.disp_rdata = bus.disp_rvalid ? rd_val : disp_hold;
  assign bus.cpu_rdata  = bus.cpu_rvalid  ? rd_val : cpu_hold;

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpu_stall_cnt <= '0;
    else if (bus.cpu_req && !bus.cpu_gnt && cpu_stall_cnt != 16'hFFFF)
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a small VRAM model.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_ready;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter_if bus ();

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  vram_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_ready     (mem_ready),
`ifdef VRAM_ARB_STATS_EN
    .cpu_stall_cnt (cpu_stall_cnt),
`endif
    .bus           (bus.slave)
  );

  // Synchronous-read VRAM: data one cycle after mem_en.
  logic [DATA_W-1:0] vram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) vram[i] = '0;
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= vram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; drive there, check 4ns later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_reqs();
    bus.disp_req = 0; bus.disp_urgent = 0; bus.disp_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  initial begin
    int ngnt;
    rst_n = 0; mem_ready = 0;
    idle_reqs();
    repeat (3) step();
    settle();
    chk("rst_disp_gnt", bus.disp_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_disp_rvalid", bus.disp_rvalid, 0);
    step(); rst_n = 1;

    // 1: no grants while VRAM not ready
    bus.disp_req = 1; bus.disp_addr = 14'd2;
    bus.cpu_req = 1; bus.cpu_addr = 14'd1;
    for (int i = 0; i < 10; i++) begin
      step(); settle();
      chk("wait_gnt", {bus.disp_gnt, bus.cpu_gnt}, 0);
      chk("wait_mem_en", bus.mem_en, 0);
    end
    step(); mem_ready = 1; settle();
    chk("ready_cpu_gnt", bus.cpu_gnt, 1);
    chk("ready_disp_gnt", bus.disp_gnt, 0);

    // 3: continued non-urgent contention alternates DISP, CPU, ...
    for (int i = 0; i < 6; i++) begin
      step(); settle();
      chk("rr_disp_gnt", bus.disp_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_cpu_gnt", bus.cpu_gnt, (i % 2 == 0) ? 0 : 1);
    end

    // 2: urgent display starves the CPU
    step(); bus.disp_urgent = 1;
    ngnt = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (bus.disp_gnt) ngnt++;
      chk("urg_cpu_gnt", bus.cpu_gnt, 0);
      step();
    end
    chk("urg_disp_cnt", ngnt, 8);
    idle_reqs();
    repeat (3) step();

    // 4: CPU write then display read-back
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'd5; bus.cpu_wdata = 16'hBEEF;
    settle();
    chk("wr_cpu_gnt", bus.cpu_gnt, 1);
    step(); idle_reqs(); settle();
    chk("wr_mem", {bus.mem_en, bus.mem_we, 2'b00, bus.mem_addr, bus.mem_wdata}, {2'b11, 2'b00, 14'd5, 16'hBEEF});
    step();
    bus.disp_req = 1; bus.disp_addr = 14'd5; settle();
    chk("wr_no_rvalid", bus.cpu_rvalid, 0);
    chk("rd_disp_gnt", bus.disp_gnt, 1);
    step(); idle_reqs(); settle();
    chk("rd_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 14'd5});
    step(); settle();
    chk("rd_disp_rvalid", bus.disp_rvalid, 1);
    chk("rd_disp_rdata", bus.disp_rdata, 16'hBEEF);
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 0);
    step(); settle();
    chk("rd_hold_rvalid", bus.disp_rvalid, 0);
    chk("rd_hold_rdata", bus.disp_rdata, 16'hBEEF);

    // 5: CPU in-range read, then out-of-range read and write
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'd5;
    step(); idle_reqs();
    step(); settle();
    chk("cpu_rd_rvalid", bus.cpu_rvalid, 1);
    chk("cpu_rd_rdata", bus.cpu_rdata, 16'hBEEF);
    bus.cpu_req = 1; bus.cpu_addr = 14'd9600; settle();
    chk("oor_rd_gnt", bus.cpu_gnt, 1);
    step(); idle_reqs(); settle();
    chk("oor_rd_mem_en", bus.mem_en, 0);
    step(); settle();
    chk("oor_rd_rvalid", bus.cpu_rvalid, 1);
    chk("oor_rd_rdata", bus.cpu_rdata, 0);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'd9600; bus.cpu_wdata = 16'h1234;
    settle();
    chk("oor_wr_gnt", bus.cpu_gnt, 1);
    step(); idle_reqs(); settle();
    chk("oor_wr_mem", {bus.mem_en, bus.mem_we}, 0);
    step(); settle();
    chk("oor_wr_rvalid", bus.cpu_rvalid, 0);
    chk("oor_rdata_hold", bus.cpu_rdata, 0);

    // 6: reset right after a grant drops the response and the pointer
    step();
    bus.disp_req = 1; bus.disp_addr = 14'd5;
    settle();
    chk("pre_rst_gnt", bus.disp_gnt, 1);
    step(); idle_reqs(); rst_n = 0; settle();
    chk("rst_mem_en2", bus.mem_en, 0);
    step(); settle();
    chk("rst_no_rvalid", bus.disp_rvalid, 0);
    chk("rst_rdata", bus.disp_rdata, 0);
    step(); rst_n = 1;
    bus.disp_req = 1; bus.cpu_req = 1; bus.cpu_addr = 14'd1;
    settle();
    chk("rst_ptr_cpu", bus.cpu_gnt, 1);
    chk("rst_ptr_disp", bus.disp_gnt, 0);
    step(); idle_reqs();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
